// File: rtl/regfile_writeback.sv
// Write-back arbiter merging ALU and memory results into one register-bank write port.
// Optional forwarding lookups are compiled in with `define REGFILE_WRITEBACK_FORWARD_EN.
module regfile_writeback #(
    parameter int REGISTER_SIZE = 32,
    parameter int ADDRESS_SIZE  = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_SIZE-1:0]  alu_addr,
    input  logic [REGISTER_SIZE-1:0] alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_SIZE-1:0]  mem_addr,
    input  logic [REGISTER_SIZE-1:0] mem_data,
    output logic                     wb_write,
    output logic [ADDRESS_SIZE-1:0]  wb_addr,
    output logic [REGISTER_SIZE-1:0] wb_data,
    input  logic [ADDRESS_SIZE-1:0]  fwd_addr1,
    input  logic [ADDRESS_SIZE-1:0]  fwd_addr2,
    output logic                     fwd_hit1,
    output logic                     fwd_hit2,
    output logic [REGISTER_SIZE-1:0] fwd_data1,
    output logic [REGISTER_SIZE-1:0] fwd_data2
);

    typedef enum logic {PRIO_MEM = 1'b0, PRIO_ALU = 1'b1} prio_e;

    logic                     alu_v_q, alu_v_d;
    logic [ADDRESS_SIZE-1:0]  alu_addr_q, alu_addr_d;
    logic [REGISTER_SIZE-1:0] alu_data_q, alu_data_d;
    logic                     mem_v_q, mem_v_d;
    logic [ADDRESS_SIZE-1:0]  mem_addr_q, mem_addr_d;
    logic [REGISTER_SIZE-1:0] mem_data_q, mem_data_d;
    prio_e                    prio_q, prio_d;
    logic                     wb_write_q, wb_write_d;
    logic [ADDRESS_SIZE-1:0]  wb_addr_q, wb_addr_d;
    logic [REGISTER_SIZE-1:0] wb_data_q, wb_data_d;

    logic grant_alu, grant_mem, alu_accept, mem_accept;

    always_comb begin
        grant_mem  = mem_v_q & (~alu_v_q | (prio_q == PRIO_MEM));
        grant_alu  = alu_v_q & (~mem_v_q | (prio_q == PRIO_ALU));
        alu_ready  = ~reset & (~alu_v_q | grant_alu);
        mem_ready  = ~reset & (~mem_v_q | grant_mem);
        alu_accept = alu_valid & alu_ready;
        mem_accept = mem_valid & mem_ready;
    end

    always_comb begin
        alu_v_d    = alu_v_q;
        alu_addr_d = alu_addr_q;
        alu_data_d = alu_data_q;
        mem_v_d    = mem_v_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        prio_d     = prio_q;
        wb_write_d = grant_alu | grant_mem;
        wb_addr_d  = wb_addr_q;
        wb_data_d  = wb_data_q;

        // A refill on the grant edge wins over the clear, keeping the buffer valid.
        if (alu_accept) begin
            alu_v_d    = 1'b1;
            alu_addr_d = alu_addr;
            alu_data_d = alu_data;
        end else if (grant_alu) begin
            alu_v_d = 1'b0;
        end

        if (mem_accept) begin
            mem_v_d    = 1'b1;
            mem_addr_d = mem_addr;
            mem_data_d = mem_data;
        end else if (grant_mem) begin
            mem_v_d = 1'b0;
        end

        if (grant_mem) begin
            wb_addr_d = mem_addr_q;
            wb_data_d = mem_data_q;
            if (alu_v_q) prio_d = PRIO_ALU;
        end else if (grant_alu) begin
            wb_addr_d = alu_addr_q;
            wb_data_d = alu_data_q;
            if (mem_v_q) prio_d = PRIO_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            alu_v_q    <= 1'b0;
            alu_addr_q <= '0;
            alu_data_q <= '0;
            mem_v_q    <= 1'b0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            prio_q     <= PRIO_MEM;
            wb_write_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_data_q  <= '0;
        end else begin
            alu_v_q    <= alu_v_d;
            alu_addr_q <= alu_addr_d;
            alu_data_q <= alu_data_d;
            mem_v_q    <= mem_v_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            prio_q     <= prio_d;
            wb_write_q <= wb_write_d;
            wb_addr_q  <= wb_addr_d;
            wb_data_q  <= wb_data_d;
        end
    end

    assign wb_write = wb_write_q;
    assign wb_addr  = wb_addr_q;
    assign wb_data  = wb_data_q;

`ifdef REGFILE_WRITEBACK_FORWARD_EN
    logic                     win_v, lose_v;
    logic [ADDRESS_SIZE-1:0]  win_addr, lose_addr;
    logic [REGISTER_SIZE-1:0] win_data, lose_data;

    always_comb begin
        win_v  = grant_alu | grant_mem;
        lose_v = alu_v_q & mem_v_q;
        if (grant_mem) begin
            win_addr  = mem_addr_q;
            win_data  = mem_data_q;
            lose_addr = alu_addr_q;
            lose_data = alu_data_q;
        end else begin
            win_addr  = alu_addr_q;
            win_data  = alu_data_q;
            lose_addr = mem_addr_q;
            lose_data = mem_data_q;
        end
    end

    // Youngest value wins: the losing buffer will be written after the granted one.
    function automatic logic [REGISTER_SIZE:0] fwd_lookup(input logic [ADDRESS_SIZE-1:0] a);
        fwd_lookup = '0;
        if (wb_write_q && wb_addr_q == a) fwd_lookup = {1'b1, wb_data_q};
        if (win_v && win_addr == a)       fwd_lookup = {1'b1, win_data};
        if (lose_v && lose_addr == a)     fwd_lookup = {1'b1, lose_data};
    endfunction

    always_comb {fwd_hit1, fwd_data1} = fwd_lookup(fwd_addr1);
    always_comb {fwd_hit2, fwd_data2} = fwd_lookup(fwd_addr2);
`else
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 Parameter REGISTER_SIZE, default 32, sets the data width of every data port and buffer.
REQ-002 Parameter ADDRESS_SIZE, default 5, sets the register address width.
REQ-003 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  is the synchronous, active-high reset.
REQ-005 Ports alu_valid in 1, alu_ready out 1, alu_addr in ADDRESS_SIZE, alu_data in REGISTER_SIZE form the ALU result source.
REQ-006 Ports mem_valid in 1, mem_ready out 1, mem_addr in ADDRESS_SIZE, mem_data in REGISTER_SIZE form the memory result source.
REQ-007 Ports wb_write out 1, wb_addr out ADDRESS_SIZE, wb_data out REGISTER_SIZE drive the register bank write port (write, addr_in, data_in).
REQ-008 Ports fwd_addr1, fwd_addr2 in ADDRESS_SIZE; fwd_hit1, fwd_hit2 out 1; fwd_data1, fwd_data2 out REGISTER_SIZE form two forwarding lookups paralleling the bank read ports.

Function
REQ-009 Each source SHALL own one holding buffer (valid, addr, data).
REQ-010 Source ready SHALL be high when reset is low and its buffer is empty or is granted this cycle.
REQ-011 A transfer SHALL occur on an edge where valid and ready are both high; the buffer loads addr/data and becomes valid.
REQ-012 A buffer granted and refilled on the same edge SHALL hold the new entry, valid.
REQ-013 Each cycle the arbiter SHALL grant at most one valid buffer: the only valid one, or, if both valid, the source not granted most recently (round-robin pointer).
REQ-014 The round-robin pointer SHALL update only on a grant made while both buffers were valid.
REQ-015 On the edge ending a grant cycle, wb_addr/wb_data SHALL load the granted entry, wb_write SHALL be 1, and that buffer SHALL clear unless refilled.
REQ-016 wb_write SHALL be 0 after any edge with no grant; wb_addr/wb_data SHALL hold their previous values.
REQ-017 Latency from accepting transfer edge to wb_write high SHALL be exactly one cycle when uncontended; sustained throughput SHALL be one write per cycle.
REQ-018 Entries with equal addresses in both buffers SHALL be written in grant order; no merging or dropping.
REQ-019 Address 0 SHALL be written like any other address (no hardwired zero register).

Reset
REQ-020 While reset is high, alu_ready and mem_ready SHALL be 0 and no transfer SHALL be accepted.
REQ-021 After a reset edge: both buffers invalid, wb_write=0, wb_addr=0, wb_data=0, fwd_hit1/2=0, pointer set so mem wins the first tie.
REQ-022 Reset asserted mid-operation SHALL discard all buffered entries without writing them.

Configuration
REQ-023 Macro REGFILE_WRITEBACK_FORWARD_EN compiles in the forwarding lookups.
REQ-024 With the macro defined, fwd_hitN SHALL be combinationally high when fwd_addrN matches a valid buffer or the wb register while wb_write=1; priority: losing buffer > granted buffer > wb register; fwd_dataN = matching data.
REQ-025 With the macro undefined, fwd_hit1/2 SHALL be constant 0 and fwd_data1/2 constant 0; no comparators synthesized.

Verification
REQ-026 Single ALU transfer addr=3 data=0xDEADBEEF at edge N -> wb_write=1, wb_addr=3, wb_data=0xDEADBEEF for one cycle after edge N+1 only.
REQ-027 Both sources valid every cycle, mem addr=1, alu addr=2 -> wb_addr alternates 1,2,1,2 starting with 1 after reset; one write per cycle.
REQ-028 Both buffers full with addr=5 (mem 0x11, alu 0x22), fwd_addr1=5 -> fwd_hit1=1, fwd_data1=0x22 (losing alu buffer); final bank value is 0x22.
REQ-029 Buffers full, reset pulsed one cycle -> no wb_write follows; readies 0 during reset, 1 on the next cycle.
REQ-030 Macro undefined, any traffic, fwd_addr1=fwd_addr2=buffered address -> fwd_hit1=fwd_hit2=0 throughout.
